// File: rtl/adx112_scan_scheduler.sv
// Round-robin single-shot scanner for the ADX112 SPI driver; re-tags pipelined readback to the previous frame's channel.
// Latency: begin to next begin = frame + CONV_WAIT_CYCLES + 3 clk; begin is held off while the driver reports busy.
module adx112_scan_scheduler #(
    parameter int          CONV_WAIT_CYCLES = 800000,
    parameter int          TIMEOUT_CYCLES   = 100000,
    parameter logic [2:0]  PGA              = 3'b001,
    parameter logic [2:0]  DR               = 3'b100
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        scan_en,
    input  logic [3:0]  ch_mask,
    output logic        adx112_begin,
    input  logic        adx112_is_busy,
    output logic [15:0] adx112_config_value,
    input  logic [15:0] adx112_dout,
    input  logic        adx112_dout_valid,
    output logic [15:0] result_data,
    output logic [1:0]  result_ch,
    output logic        result_valid,
    output logic        scan_busy,
    output logic        timeout_err
);

    localparam int CNT_MAX = (CONV_WAIT_CYCLES > TIMEOUT_CYCLES) ? CONV_WAIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CW_LAST = CNT_W'(CONV_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_FLUSH, S_ISSUE, S_WAIT_DONE, S_CONV_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        ch_q, ch_d;
    logic [1:0]        last_ch_q, last_ch_d;
    logic [15:0]       cfg_q, cfg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_vld_q, pend_vld_d;
    logic [1:0]        pend_ch_q, pend_ch_d;
    logic              flush_q, flush_d;
    logic              begin_q, begin_d;
    logic              res_vld_q, res_vld_d;
    logic [15:0]       res_dat_q, res_dat_d;
    logic [1:0]        res_ch_q, res_ch_d;
    logic              tmo_q, tmo_d;
    logic [1:0]        sel_ch;
    logic              scan_go;

    // First enabled channel strictly after 'last', wrapping; offset 4 lands back on 'last'.
    function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] last);
        logic [1:0] c;
        next_ch = last;
        for (int i = 4; i >= 1; i--) begin
            c = last + 2'(i);
            if (m[c]) next_ch = c;
        end
    endfunction

    function automatic logic [15:0] cfg_word(input logic [1:0] c);
        cfg_word = {1'b1, 1'b1, c, PGA, 1'b1, DR, 1'b0, 1'b1, 2'b01, 1'b1};
    endfunction

    assign sel_ch  = next_ch(ch_mask, last_ch_q);
    assign scan_go = scan_en && (ch_mask != 4'd0);

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        last_ch_d  = last_ch_q;
        cfg_d      = cfg_q;
        cnt_d      = cnt_q;
        pend_vld_d = pend_vld_q;
        pend_ch_d  = pend_ch_q;
        flush_d    = flush_q;
        begin_d    = 1'b0;
        res_vld_d  = 1'b0;
        res_dat_d  = res_dat_q;
        res_ch_d   = res_ch_q;
        tmo_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // last_ch=3 makes the next search start at AIN0
                last_ch_d = 2'd3;
                flush_d   = 1'b0;
                if (scan_go) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (ch_mask != 4'd0) begin
                    ch_d      = sel_ch;
                    last_ch_d = sel_ch;
                    cfg_d     = cfg_word(sel_ch);
                    flush_d   = 1'b0;
                    state_d   = S_ISSUE;
                end else begin
                    state_d = pend_vld_q ? S_FLUSH : S_IDLE;
                end
            end
            S_FLUSH: begin
                // SS=0 and NOP=00: clock out the last result without starting a conversion
                cfg_d   = {1'b0, cfg_q[14:3], 2'b00, cfg_q[0]};
                flush_d = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!adx112_is_busy) begin
                    begin_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (adx112_dout_valid) begin
                    res_vld_d = pend_vld_q;
                    if (pend_vld_q) begin
                        res_dat_d = adx112_dout;
                        res_ch_d  = pend_ch_q;
                    end
                    pend_ch_d  = ch_q;
                    pend_vld_d = !flush_q;
                    cnt_d      = '0;
                    state_d    = flush_q ? S_IDLE : S_CONV_WAIT;
                end else if (cnt_q == TO_LAST) begin
                    tmo_d      = 1'b1;
                    pend_vld_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CONV_WAIT: begin
                if (cnt_q == CW_LAST) begin
                    cnt_d = '0;
                    if (scan_go)         state_d = S_SELECT;
                    else if (pend_vld_q) state_d = S_FLUSH;
                    else                 state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            ch_q       <= 2'd0;
            last_ch_q  <= 2'd3;
            cfg_q      <= 16'h0000;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_ch_q  <= 2'd0;
            flush_q    <= 1'b0;
            begin_q    <= 1'b0;
            res_vld_q  <= 1'b0;
            res_dat_q  <= 16'h0000;
            res_ch_q   <= 2'd0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            last_ch_q  <= last_ch_d;
            cfg_q      <= cfg_d;
            cnt_q      <= cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_ch_q  <= pend_ch_d;
            flush_q    <= flush_d;
            begin_q    <= begin_d;
            res_vld_q  <= res_vld_d;
            res_dat_q  <= res_dat_d;
            res_ch_q   <= res_ch_d;
            tmo_q      <= tmo_d;
        end
    end

    assign adx112_begin        = begin_q;
    assign adx112_config_value = cfg_q;
    assign result_valid        = res_vld_q;
    assign result_data         = res_dat_q;
    assign result_ch           = res_ch_q;
    assign timeout_err         = tmo_q;
    assign scan_busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_adx112_scan_scheduler.sv
// Bench for adx112_scan_scheduler: behavioural driver model plus a frame-level reference of the scan schedule.
module tb_adx112_scan_scheduler;

    localparam int CW = 20;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rstn, scan_en;
    logic [3:0]  ch_mask;
    logic        adx112_begin, adx112_is_busy, adx112_dout_valid;
    logic [15:0] adx112_config_value, adx112_dout;
    logic [15:0] result_data;
    logic [1:0]  result_ch;
    logic        result_valid, scan_busy, timeout_err;

    logic drv_busy = 1'b0, busy_force = 1'b0, drv_dv = 1'b0, stray_dv = 1'b0;
    assign adx112_is_busy    = drv_busy | busy_force;
    assign adx112_dout_valid = drv_dv | stray_dv;

    adx112_scan_scheduler #(.CONV_WAIT_CYCLES(CW), .TIMEOUT_CYCLES(TO), .PGA(3'b001), .DR(3'b100)) dut (
        .clk(clk), .rstn(rstn), .scan_en(scan_en), .ch_mask(ch_mask),
        .adx112_begin(adx112_begin), .adx112_is_busy(adx112_is_busy),
        .adx112_config_value(adx112_config_value), .adx112_dout(adx112_dout),
        .adx112_dout_valid(adx112_dout_valid), .result_data(result_data),
        .result_ch(result_ch), .result_valid(result_valid),
        .scan_busy(scan_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0, viol = 0;
    int nbeg = 0, nres = 0, nto = 0, cur = 0, remain = 0, mute_idx = -1;
    bit active = 1'b0, prev_begin = 1'b0;
    int          beg_cyc[64], fr_dv[64], res_cyc[64], to_cyc[64];
    logic [15:0] beg_word[64], fr_dat[64], res_dat[64];
    logic [1:0]  res_chv[64];
    logic [15:0] words[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor + driver model: observe outputs first, then drive the driver-side inputs.
    initial begin
        adx112_dout = 16'h0000;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (adx112_begin) begin
                if (adx112_is_busy || prev_begin) viol++;
                if (nbeg < 64) begin
                    beg_cyc[nbeg]  = cyc;
                    beg_word[nbeg] = adx112_config_value;
                end
                cur = nbeg;
                nbeg++;
            end
            prev_begin = adx112_begin;
            if (result_valid && nres < 64) begin
                res_cyc[nres] = cyc; res_chv[nres] = result_ch; res_dat[nres] = result_data;
                nres++;
            end
            if (timeout_err && nto < 64) begin
                to_cyc[nto] = cyc;
                nto++;
            end
            if (drv_dv) begin
                drv_dv = 1'b0; drv_busy = 1'b0;
            end else if (active) begin
                remain--;
                if (remain <= 0) begin
                    if (adx112_config_value !== beg_word[cur]) viol++;
                    adx112_dout = 16'($urandom);
                    fr_dat[cur] = adx112_dout;
                    fr_dv[cur]  = cyc;
                    drv_dv = 1'b1; active = 1'b0;
                end
            end
            if (adx112_begin && cur != mute_idx) begin
                drv_busy = 1'b1; active = 1'b1;
                remain = int'($urandom_range(3, 10));
            end
        end
    end

    // One scan burst: n frames started with scan_en=1, then scan stopped during frame n-1.
    task automatic run_scan(input logic [3:0] m, input int n, input int mute, input bit hold, input bit drop_mask);
        int enl[$];
        int pos, pend, ch, last, b, rel, nexp;
        int exp_ch[64], exp_fr[64];
        logic [15:0] exw[64];
        nbeg = 0; nres = 0; nto = 0; mute_idx = mute;
        @(posedge clk); #3;
        ch_mask = m; scan_en = 1'b1;
        if (hold) begin
            busy_force = 1'b1;
            repeat (12) @(posedge clk);
            #3;
            busy_force = 1'b0;
            rel = cyc;
            chk("busy_hold_no_begin", nbeg, 0);
        end
        b = 0;
        while (nbeg < n && b < 3000) begin @(posedge clk); #3; b++; end
        chk("wait_begins", (nbeg >= n), 1);
        if (drop_mask) ch_mask = 4'd0; else scan_en = 1'b0;
        chk("scan_busy_on", scan_busy, 1);
        b = 0;
        while (scan_busy && b < 3000) begin @(posedge clk); #3; b++; end
        repeat (5) @(posedge clk);
        #3;
        chk("scan_busy_off", scan_busy, 0);
        scan_en = 1'b0;
        if (hold) chk("busy_hold_begin", beg_cyc[0], rel + 1);

        // Reference: enabled channels in ascending order, restarting at AIN0 after a timeout.
        for (int c = 0; c < 4; c++) if (m[c]) enl.push_back(c);
        pos = 0; pend = -1; nexp = 0; last = 0;
        for (int k = 0; k < n; k++) begin
            ch = enl[pos % enl.size()];
            pos++;
            exw[k] = words[ch];
            last = ch;
            if (k == mute) begin
                pend = -1; pos = 0;
            end else begin
                if (pend >= 0) begin exp_ch[nexp] = pend; exp_fr[nexp] = k; nexp++; end
                pend = ch;
            end
        end
        exw[n] = words[last] & 16'h7FF9;
        if (pend >= 0) begin exp_ch[nexp] = pend; exp_fr[nexp] = n; nexp++; end

        chk("n_begins", nbeg, n + 1);
        for (int k = 0; k <= n && k < nbeg; k++)
            chk($sformatf("word%0d", k), beg_word[k], exw[k]);
        for (int k = 0; k < n && k + 1 < nbeg; k++)
            if (k != mute) chk($sformatf("gap%0d", k), beg_cyc[k+1] - fr_dv[k], CW + 3);
        chk("n_results", nres, nexp);
        for (int j = 0; j < nexp && j < nres; j++) begin
            chk($sformatf("res_ch%0d", j), res_chv[j], exp_ch[j]);
            chk($sformatf("res_dat%0d", j), res_dat[j], fr_dat[exp_fr[j]]);
            chk($sformatf("res_cyc%0d", j), res_cyc[j], fr_dv[exp_fr[j]] + 1);
        end
        chk("n_timeouts", nto, (mute >= 0) ? 1 : 0);
        if (mute >= 0 && nto > 0) chk("timeout_cyc", to_cyc[0] - beg_cyc[mute], TO);
        mute_idx = -1;
    endtask

    initial begin
        int b, nres0, nbeg0;
        words[0] = 16'hC38B; words[1] = 16'hD38B; words[2] = 16'hE38B; words[3] = 16'hF38B;
        rstn = 1'b0; scan_en = 1'b0; ch_mask = 4'd0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_begin", adx112_begin, 0);
        chk("rst_cfg", adx112_config_value, 16'h0000);
        chk("rst_rvld", result_valid, 0);
        chk("rst_rdat", result_data, 16'h0000);
        chk("rst_rch", result_ch, 0);
        chk("rst_busy", scan_busy, 0);
        chk("rst_tmo", timeout_err, 0);
        rstn = 1'b1;

        run_scan(4'b0101, 4, -1, 1'b0, 1'b0);
        run_scan(4'b1000, 4, -1, 1'b0, 1'b0);
        run_scan(4'b0011, 2, -1, 1'b0, 1'b0);
        run_scan(4'($urandom_range(1, 15)), 5, 1, 1'b0, 1'b0);
        run_scan(4'($urandom_range(1, 15)), 3, -1, 1'b1, 1'b0);
        run_scan(4'($urandom_range(1, 15)), 4, -1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            run_scan(4'($urandom_range(1, 15)), int'($urandom_range(2, 5)), -1, 1'b0, 1'b0);

        // Reset during CONV_WAIT with a result pending.
        nbeg = 0; nres = 0; nto = 0;
        @(posedge clk); #3;
        ch_mask = 4'b0110; scan_en = 1'b1;
        b = 0;
        while ((nbeg < 2 || active || drv_dv) && b < 3000) begin @(posedge clk); #3; b++; end
        chk("rst_wait_frames", (nbeg >= 2), 1);
        repeat (5) @(posedge clk);
        #3;
        rstn = 1'b0; scan_en = 1'b0;
        @(posedge clk); #3;
        rstn = 1'b1;
        chk("mid_rst_begin", adx112_begin, 0);
        chk("mid_rst_cfg", adx112_config_value, 16'h0000);
        chk("mid_rst_rvld", result_valid, 0);
        chk("mid_rst_rdat", result_data, 16'h0000);
        chk("mid_rst_rch", result_ch, 0);
        chk("mid_rst_busy", scan_busy, 0);
        chk("mid_rst_tmo", timeout_err, 0);
        nres0 = nres; nbeg0 = nbeg;
        stray_dv = 1'b1;
        @(posedge clk); #3;
        stray_dv = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        chk("post_rst_no_result", nres, nres0);
        chk("post_rst_no_begin", nbeg, nbeg0);

        chk("begin_rules", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
